fetch_unit: RTL

Instruction-fetch front end of the pipelined ARM (LEGv8) core. It holds the program counter, drives the instruction-memory address, and buffers fetched instructions in a 2-entry queue. It presents them to the IF/ID pipeline register with a valid/ready handshake, so fetch keeps running while decode stalls. Branch redirects from the execute stage flush the queue and reload the PC.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo2.sv | 55 +++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int N       = 64;
    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo2
// Brief    : Two-entry FIFO with synchronous flush, holding fetched {pc, instr}.
// Revision : 1.0
// ============================================================================
module fetch_fifo2
    import fetch_pkg::*;
#(
    parameter int W = $bits(fetch_entry_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Flush dominates push/pop; storage is kept so the head shows a stale slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC register, fetch FSM and 2-entry queue feeding IF/ID.
//            Optional FETCH_PERF_EN adds a saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::fetch_state_t, fetch_pkg::BOOT, fetch_pkg::RUN,
           fetch_pkg::HALT, fetch_pkg::PC_INCR;
#(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    input  logic         halt,
    output logic [N-1:0] pc_o,
    output logic [31:0]  instr_o,
    output logic         valid_o,
    input  logic         ready_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  stall_cycles_o
`endif
);

    localparam logic [N-1:0] c_pc_step    = N'(PC_INCR);
    localparam logic [N-1:0] c_align_mask = ~(N'(3));

    fetch_state_t  state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic          w_fetch_en;
    logic          w_deq;
    logic          w_enq;
    logic [1:0]    w_count;
    logic [N+31:0] w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (br_taken) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = halt ? HALT : RUN;
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_comb begin
        w_fetch_en = (state_q == RUN);
    end

    // A dequeue in the same cycle frees a slot, so a full queue keeps streaming.
    assign valid_o = (w_count != 2'd0);
    assign w_deq   = valid_o & ready_i;
    assign w_enq   = w_fetch_en & ~br_taken & ((w_count != 2'd2) | w_deq);

    always_comb begin
        pc_d = pc_q;
        if (br_taken) begin
            pc_d = br_target & c_align_mask;
        end else if (w_enq) begin
            pc_d = pc_q + c_pc_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo2 #(
        .W (N + 32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_enq),
        .pop   (w_deq),
        .flush (br_taken),
        .din   ({pc_q, imem_rdata}),
        .dout  (w_head),
        .count (w_count)
    );

    assign imem_addr = pc_q;
    assign pc_o      = w_head[N+31:32];
    assign instr_o   = w_head[31:0];

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
        end else if (valid_o && !ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule
`default_nettype wire
